// File: rtl/pipe_hazard_ctrl.sv
// Stall, flush and LM/SM sequencing controller for the 5-stage pipeline.
// Drives the PC / IF/ID / ID/EX enables, NOP and bubble inserts, and per-register micro-ops.
module pipe_hazard_ctrl #(
  parameter int STALL_CNT_W = 16,
  parameter int MASK_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_busy,
  input  logic                   ex_mispredict,
  input  logic                   ex_valid,
  input  logic                   ex_is_load,
  input  logic                   ex_wr_en,
  input  logic [2:0]             ex_rd,
  input  logic                   id_valid,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [2:0]             id_rs1,
  input  logic [2:0]             id_rs2,
  input  logic                   id_is_lmsm,
  input  logic [MASK_W-1:0]      id_mask,
  output logic                   pc_en,
  output logic                   if2id_en,
  output logic                   id2ex_en,
  output logic                   if2id_flush,
  output logic                   id2ex_bubble,
  output logic                   uop_valid,
  output logic [2:0]             uop_reg,
  output logic [2:0]             uop_offset,
  output logic                   lmsm_busy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic {IDLE, SEQ} state_e;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_FREEZE,
    ACT_FLUSH,
    ACT_SEQ,
    ACT_LOAD_USE,
    ACT_START,
    ACT_EMPTY
  } act_e;

  state_e                 state_q, state_d;
  logic [MASK_W-1:0]      rem_mask_q, rem_mask_d;
  logic [2:0]             off_cnt_q, off_cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  act_e              act;
  logic              load_use;
  logic [MASK_W-1:0] seq_rest;
  logic [MASK_W-1:0] start_rest;

  function automatic logic [MASK_W-1:0] low_bit(input logic [MASK_W-1:0] m);
    return m & (~m + MASK_W'(1));
  endfunction

  function automatic logic [2:0] low_idx(input logic [MASK_W-1:0] m);
    logic [2:0] idx;
    idx = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign load_use = id_valid && ex_valid && ex_is_load && ex_wr_en &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  assign seq_rest   = rem_mask_q & ~low_bit(rem_mask_q);
  assign start_rest = id_mask & ~low_bit(id_mask);

  // One decision per cycle, in strict priority order.
  always_comb begin
    act = ACT_NONE;
    if (mem_busy)                   act = ACT_FREEZE;
    else if (ex_mispredict)         act = ACT_FLUSH;
    else if (state_q == SEQ)        act = ACT_SEQ;
    else if (load_use)              act = ACT_LOAD_USE;
    else if (id_valid && id_is_lmsm) act = (id_mask != '0) ? ACT_START : ACT_EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_mask_q  <= '0;
      off_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rem_mask_q <= rem_mask_d;
      off_cnt_q  <= off_cnt_d;
      if (!pc_en && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  // NOTE: every next-state signal is defaulted to hold first, so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    rem_mask_d = rem_mask_q;
    off_cnt_d  = off_cnt_q;
    unique case (act)
      ACT_FLUSH: begin
        state_d    = IDLE;
        rem_mask_d = '0;
        off_cnt_d  = '0;
      end
      ACT_SEQ: begin
        rem_mask_d = seq_rest;
        off_cnt_d  = off_cnt_q + 3'd1;
        state_d    = (seq_rest != '0) ? SEQ : IDLE;
      end
      ACT_START: begin
        rem_mask_d = start_rest;
        off_cnt_d  = 3'd1;
        state_d    = (start_rest != '0) ? SEQ : IDLE;
      end
      default: ;
    endcase
  end

  // Combinational outputs are forced low while rst is high, not only after the next edge.
  always_comb begin
    pc_en        = 1'b0;
    if2id_en     = 1'b0;
    id2ex_en     = 1'b0;
    if2id_flush  = 1'b0;
    id2ex_bubble = 1'b0;
    uop_valid    = 1'b0;
    uop_reg      = '0;
    uop_offset   = '0;
    if (!rst) begin
      unique case (act)
        ACT_NONE: begin
          pc_en    = 1'b1;
          if2id_en = 1'b1;
          id2ex_en = 1'b1;
        end
        ACT_FREEZE: ;
        ACT_FLUSH: begin
          pc_en        = 1'b1;
          if2id_en     = 1'b1;
          id2ex_en     = 1'b1;
          if2id_flush  = 1'b1;
          id2ex_bubble = 1'b1;
        end
        ACT_SEQ: begin
          id2ex_en   = 1'b1;
          uop_valid  = 1'b1;
          uop_reg    = low_idx(rem_mask_q);
          uop_offset = off_cnt_q;
          pc_en      = (seq_rest == '0);
          if2id_en   = (seq_rest == '0);
        end
        ACT_LOAD_USE: begin
          id2ex_en     = 1'b1;
          id2ex_bubble = 1'b1;
        end
        ACT_START: begin
          id2ex_en  = 1'b1;
          uop_valid = 1'b1;
          uop_reg   = low_idx(id_mask);
          pc_en     = (start_rest == '0);
          if2id_en  = (start_rest == '0);
        end
        ACT_EMPTY: begin
          pc_en        = 1'b1;
          if2id_en     = 1'b1;
          id2ex_en     = 1'b1;
          id2ex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign lmsm_busy = (state_q == SEQ);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios followed by random traffic,
// checked against a queue-based model of pending LM/SM registers.
module tb_pipe_hazard_ctrl;

  localparam int CW = 6;
  localparam int MW = 8;

  typedef struct packed {
    logic          rst;
    logic          mem_busy;
    logic          mispredict;
    logic          ex_valid;
    logic          ex_is_load;
    logic          ex_wr_en;
    logic [2:0]    ex_rd;
    logic          id_valid;
    logic          uses_rs1;
    logic          uses_rs2;
    logic [2:0]    rs1;
    logic [2:0]    rs2;
    logic          is_lmsm;
    logic [MW-1:0] mask;
  } stim_t;

  typedef struct packed {
    logic          pc_en;
    logic          if2id_en;
    logic          id2ex_en;
    logic          flush;
    logic          bubble;
    logic          uop_valid;
    logic [2:0]    uop_reg;
    logic [2:0]    uop_offset;
    logic          busy;
    logic [CW-1:0] stall_cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_busy, ex_mispredict, ex_valid, ex_is_load, ex_wr_en;
  logic [2:0]    ex_rd;
  logic          id_valid, id_uses_rs1, id_uses_rs2, id_is_lmsm;
  logic [2:0]    id_rs1, id_rs2;
  logic [MW-1:0] id_mask;
  logic          pc_en, if2id_en, id2ex_en, if2id_flush, id2ex_bubble;
  logic          uop_valid, lmsm_busy;
  logic [2:0]    uop_reg, uop_offset;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  exp_t sb_q[$];

  // Reference model: registers still owed by the current LM/SM, next offset, stall count.
  int pending[$];
  int next_off;
  int model_cnt;

  pipe_hazard_ctrl #(.STALL_CNT_W(CW), .MASK_W(MW)) dut (
    .clk(clk), .rst(rst),
    .mem_busy(mem_busy), .ex_mispredict(ex_mispredict),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_wr_en(ex_wr_en), .ex_rd(ex_rd),
    .id_valid(id_valid), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_is_lmsm(id_is_lmsm), .id_mask(id_mask),
    .pc_en(pc_en), .if2id_en(if2id_en), .id2ex_en(id2ex_en),
    .if2id_flush(if2id_flush), .id2ex_bubble(id2ex_bubble),
    .uop_valid(uop_valid), .uop_reg(uop_reg), .uop_offset(uop_offset),
    .lmsm_busy(lmsm_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model_cycle(input stim_t s);
    exp_t e;
    int   bits[$];
    e = '0;
    if (s.rst) begin
      pending.delete();
      next_off  = 0;
      model_cnt = 0;
      return e;
    end
    e.busy      = (pending.size() > 0);
    e.stall_cnt = CW'(model_cnt);
    if (s.mem_busy) begin
      // everything frozen, nothing owed changes
    end else if (s.mispredict) begin
      e.pc_en = 1; e.if2id_en = 1; e.id2ex_en = 1; e.flush = 1; e.bubble = 1;
      pending.delete();
    end else if (pending.size() > 0) begin
      e.uop_valid  = 1;
      e.uop_reg    = 3'(pending.pop_front());
      e.uop_offset = 3'(next_off);
      next_off++;
      e.id2ex_en = 1;
      e.pc_en    = (pending.size() == 0);
      e.if2id_en = e.pc_en;
    end else if (s.id_valid && s.ex_valid && s.ex_is_load && s.ex_wr_en &&
                 ((s.uses_rs1 && s.rs1 == s.ex_rd) || (s.uses_rs2 && s.rs2 == s.ex_rd))) begin
      e.id2ex_en = 1; e.bubble = 1;
    end else if (s.id_valid && s.is_lmsm) begin
      for (int i = 0; i < MW; i++) if (s.mask[i]) bits.push_back(i);
      if (bits.size() == 0) begin
        e.pc_en = 1; e.if2id_en = 1; e.id2ex_en = 1; e.bubble = 1;
      end else begin
        e.uop_valid = 1;
        e.uop_reg   = 3'(bits.pop_front());
        e.id2ex_en  = 1;
        e.pc_en     = (bits.size() == 0);
        e.if2id_en  = e.pc_en;
        pending     = bits;
        next_off    = 1;
      end
    end else begin
      e.pc_en = 1; e.if2id_en = 1; e.id2ex_en = 1;
    end
    if (!e.pc_en && model_cnt < (1 << CW) - 1) model_cnt++;
    return e;
  endfunction

  task automatic apply(input stim_t s);
    rst           = s.rst;
    mem_busy      = s.mem_busy;
    ex_mispredict = s.mispredict;
    ex_valid      = s.ex_valid;
    ex_is_load    = s.ex_is_load;
    ex_wr_en      = s.ex_wr_en;
    ex_rd         = s.ex_rd;
    id_valid      = s.id_valid;
    id_uses_rs1   = s.uses_rs1;
    id_uses_rs2   = s.uses_rs2;
    id_rs1        = s.rs1;
    id_rs2        = s.rs2;
    id_is_lmsm    = s.is_lmsm;
    id_mask       = s.mask;
  endtask

  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    apply(s);
    sb_q.push_back(model_cycle(s));
  endtask

  // Reset raised in the middle of a cycle, outputs checked before the next edge.
  task automatic step_async_rst(input stim_t s);
    @(posedge clk);
    #1;
    apply(s);
    #1;
    rst = 1'b1;
    s.rst = 1'b1;
    sb_q.push_back(model_cycle(s));
  endtask

  function automatic stim_t idle_stim();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t lmsm_stim(input logic [MW-1:0] m);
    stim_t s;
    s = '0;
    s.id_valid = 1; s.is_lmsm = 1; s.mask = m;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    int    r;
    s = '0;
    s.rst        = ($urandom_range(0, 99) < 1);
    s.mem_busy   = ($urandom_range(0, 99) < 12);
    s.mispredict = ($urandom_range(0, 99) < 6);
    s.ex_valid   = $urandom_range(0, 1);
    s.ex_is_load = $urandom_range(0, 1);
    s.ex_wr_en   = $urandom_range(0, 1);
    s.ex_rd      = 3'($urandom_range(0, 7));
    s.id_valid   = ($urandom_range(0, 9) < 8);
    s.uses_rs1   = $urandom_range(0, 1);
    s.uses_rs2   = $urandom_range(0, 1);
    s.rs1        = 3'($urandom_range(0, 7));
    s.rs2        = 3'($urandom_range(0, 7));
    s.is_lmsm    = ($urandom_range(0, 3) == 0);
    r = $urandom_range(0, 9);
    if (r == 0)      s.mask = '0;
    else if (r == 1) s.mask = MW'(1) << $urandom_range(0, MW - 1);
    else if (r == 2) s.mask = '1;
    else             s.mask = MW'($urandom());
    return s;
  endfunction

  // Monitor: pops one expectation per cycle, compares away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("pc_en",        int'(pc_en),        int'(e.pc_en));
        check("if2id_en",     int'(if2id_en),     int'(e.if2id_en));
        check("id2ex_en",     int'(id2ex_en),     int'(e.id2ex_en));
        check("if2id_flush",  int'(if2id_flush),  int'(e.flush));
        check("id2ex_bubble", int'(id2ex_bubble), int'(e.bubble));
        check("uop_valid",    int'(uop_valid),    int'(e.uop_valid));
        check("uop_reg",      int'(uop_reg),      int'(e.uop_reg));
        check("uop_offset",   int'(uop_offset),   int'(e.uop_offset));
        check("lmsm_busy",    int'(lmsm_busy),    int'(e.busy));
        check("stall_cnt",    int'(stall_cnt),    int'(e.stall_cnt));
      end
    end
  end

  initial begin
    stim_t s;
    next_off  = 0;
    model_cnt = 0;
    s = idle_stim();
    s.rst = 1;
    apply(s);
    step(s);
    step(s);
    step(idle_stim());

    // load-use on rs2
    s = idle_stim();
    s.ex_valid = 1; s.ex_is_load = 1; s.ex_wr_en = 1; s.ex_rd = 3;
    s.id_valid = 1; s.uses_rs2 = 1; s.rs2 = 3; s.rs1 = 1;
    step(s);
    step(idle_stim());

    // LM with three registers
    step(lmsm_stim(8'b1010_0100));
    step(lmsm_stim(8'b1010_0100));
    step(lmsm_stim(8'b1010_0100));
    step(idle_stim());

    // mispredict during the second micro-op
    step(lmsm_stim(8'hFF));
    s = lmsm_stim(8'hFF);
    s.mispredict = 1;
    step(s);
    step(idle_stim());

    // memory freeze in the middle of SEQ
    step(lmsm_stim(8'h03));
    s = lmsm_stim(8'h03);
    s.mem_busy = 1;
    for (int i = 0; i < 3; i++) step(s);
    step(lmsm_stim(8'h03));
    step(idle_stim());

    // empty mask, then single-bit mask
    step(lmsm_stim(8'h00));
    step(lmsm_stim(8'h10));
    step(idle_stim());

    // asynchronous reset mid-SEQ
    step(lmsm_stim(8'hFF));
    step(lmsm_stim(8'hFF));
    step_async_rst(lmsm_stim(8'hFF));
    s = idle_stim();
    s.rst = 1;
    step(s);
    step(idle_stim());
    step(idle_stim());

    for (int n = 0; n < 3000; n++) step(rand_stim());

    step(idle_stim());
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
